// File: rtl/piano_pkg.sv
// Definitions shared by the piano recorder and the note player.
// Covers key codes, timeline width, default timing constants and the playback FSM states.
package piano_pkg;

    localparam int TIME_W       = 13;
    localparam int HALF_W       = 17;
    localparam int TICK_DIV_DEF = 500000;
    localparam int HALF_DO_DEF  = 95420;
    localparam int HALF_RE_DEF  = 85034;
    localparam int HALF_MI_DEF  = 75758;

    localparam logic [TIME_W-1:0] TIME_ONE = 13'd1;
    localparam logic [TIME_W-1:0] TIME_MAX = 13'd8191;

    typedef enum logic [1:0] {
        KEY_NONE = 2'b00,
        KEY_DO   = 2'b01,
        KEY_RE   = 2'b10,
        KEY_MI   = 2'b11
    } key_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SOUND = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] t);
        return (t == TIME_MAX) ? t : t + TIME_ONE;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator for the active key.
// The half-period counter restarts on every key change; the output is silent for KEY_NONE.
module tone_gen
    import piano_pkg::*;
#(
    parameter int HALF_DO = HALF_DO_DEF,
    parameter int HALF_RE = HALF_RE_DEF,
    parameter int HALF_MI = HALF_MI_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] key_active,
    output logic       tone_out
);

    logic [HALF_W-1:0] half_s;
    logic [HALF_W-1:0] cnt_r;
    logic              tone_r;
    logic [1:0]        key_prev_r;

    function automatic logic [HALF_W-1:0] half_of(input logic [1:0] key);
        case (key)
            KEY_DO:  return HALF_W'(HALF_DO);
            KEY_RE:  return HALF_W'(HALF_RE);
            KEY_MI:  return HALF_W'(HALF_MI);
            default: return 17'd0;
        endcase
    endfunction

    assign half_s = half_of(key_active);

    // Reloading with HALF-2 on a change puts the first rising edge HALF cycles after key onset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_r      <= 17'd0;
            tone_r     <= 1'b0;
            key_prev_r <= KEY_NONE;
        end else begin
            key_prev_r <= key_active;
            if (key_active == KEY_NONE) begin
                cnt_r  <= 17'd0;
                tone_r <= 1'b0;
            end else if (key_active != key_prev_r) begin
                cnt_r  <= half_s - 17'd2;
                tone_r <= 1'b0;
            end else if (cnt_r == 17'd0) begin
                cnt_r  <= half_s - 17'd1;
                tone_r <= ~tone_r;
            end else begin
                cnt_r <= cnt_r - 17'd1;
            end
        end
    end

    // Mask so silence and key changes show up in the same cycle as key_active.
    assign tone_out = tone_r & (key_active != KEY_NONE) & (key_active == key_prev_r);

endmodule

// File: rtl/note_player.sv
// Monophonic playback of recorded note events against a 0.01 s tick timeline.
// Events stay in the buffer after playback so a sequence can be replayed.
module note_player
    import piano_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int DEPTH    = 16,
    parameter int HALF_DO  = HALF_DO_DEF,
    parameter int HALF_RE  = HALF_RE_DEF,
    parameter int HALF_MI  = HALF_MI_DEF
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [1:0]               wr_key,
    input  logic [12:0]              wr_start,
    input  logic [12:0]              wr_dur,
    input  logic                     clear,
    input  logic                     play,
    input  logic                     stop,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic [1:0]               key_active,
    output logic                     tone_out,
    output logic [12:0]              play_time,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [1:0]        mem_key_r   [DEPTH];
    logic [TIME_W-1:0] mem_start_r [DEPTH];
    logic [TIME_W-1:0] mem_dur_r   [DEPTH];

    state_t            state_r, state_nxt_s;
    logic [CW-1:0]     count_r, count_nxt_s;
    logic              full_r, busy_r, done_r;
    logic [AW-1:0]     rd_idx_r;
    logic [PW-1:0]     presc_r;
    logic [TIME_W-1:0] play_time_r, remain_r;
    logic [1:0]        ev_key_r, key_active_r;
    logic [TIME_W-1:0] ev_start_r, ev_dur_r;
    logic              tick_s, wr_ok_s, play_go_s, play_empty_s, start_sound_s, adv_s;

    assign tick_s  = (state_r != ST_IDLE) && (presc_r == '0);
    assign wr_ok_s = (state_r == ST_IDLE) && wr_en && !clear && !full_r;

    // Next state and one-cycle control strobes; stop overrides everything.
    always_comb begin
        state_nxt_s   = state_r;
        play_go_s     = 1'b0;
        play_empty_s  = 1'b0;
        start_sound_s = 1'b0;
        adv_s         = 1'b0;
        if (stop) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (play && count_r == '0) begin
                        play_empty_s = 1'b1;
                    end else if (play) begin
                        play_go_s   = 1'b1;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: state_nxt_s = ST_WAIT;
                ST_WAIT: begin
                    if (play_time_r >= ev_start_r && ev_dur_r == '0) begin
                        state_nxt_s = ST_NEXT;
                    end else if (play_time_r >= ev_start_r) begin
                        state_nxt_s   = ST_SOUND;
                        start_sound_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_SOUND: begin
                    if (tick_s && remain_r == TIME_ONE) begin
                        state_nxt_s = ST_NEXT;
                    end else begin
                        state_nxt_s = ST_SOUND;
                    end
                end
                ST_NEXT: begin
                    if ({1'b0, rd_idx_r} == count_r - CNT_ONE) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                        adv_s       = 1'b1;
                    end
                end
                ST_DONE:  state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Buffer occupancy: clear beats a simultaneous write.
    always_comb begin
        count_nxt_s = count_r;
        if (state_r == ST_IDLE && clear) begin
            count_nxt_s = '0;
        end else if (wr_ok_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Event storage, written in arrival order.
    always_ff @(posedge CLOCK_50) begin
        if (wr_ok_s) begin
            mem_key_r[count_r[AW-1:0]]   <= wr_key;
            mem_start_r[count_r[AW-1:0]] <= wr_start;
            mem_dur_r[count_r[AW-1:0]]   <= wr_dur;
        end
    end

    // FSM state, timeline and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            full_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rd_idx_r     <= '0;
            presc_r      <= PRESC_LOAD;
            play_time_r  <= '0;
            remain_r     <= '0;
            ev_key_r     <= KEY_NONE;
            ev_start_r   <= '0;
            ev_dur_r     <= '0;
            key_active_r <= KEY_NONE;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= play_empty_s || (state_nxt_s == ST_DONE);

            if (play_go_s) begin
                presc_r     <= PRESC_LOAD;
                play_time_r <= '0;
                rd_idx_r    <= '0;
            end else begin
                if (tick_s) begin
                    presc_r     <= PRESC_LOAD;
                    play_time_r <= sat_inc(play_time_r);
                end else if (state_r != ST_IDLE) begin
                    presc_r <= presc_r - 1'b1;
                end
                if (adv_s) begin
                    rd_idx_r <= rd_idx_r + 1'b1;
                end
            end

            if (state_r == ST_FETCH) begin
                ev_key_r   <= mem_key_r[rd_idx_r];
                ev_start_r <= mem_start_r[rd_idx_r];
                ev_dur_r   <= mem_dur_r[rd_idx_r];
            end

            if (start_sound_s) begin
                remain_r <= ev_dur_r;
            end else if (state_r == ST_SOUND && tick_s) begin
                remain_r <= remain_r - TIME_ONE;
            end

            if (start_sound_s) begin
                key_active_r <= ev_key_r;
            end else if (state_nxt_s != ST_SOUND) begin
                key_active_r <= KEY_NONE;
            end
        end
    end

    assign full       = full_r;
    assign count      = count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign play_time  = play_time_r;
    assign key_active = key_active_r;

    tone_gen #(
        .HALF_DO (HALF_DO),
        .HALF_RE (HALF_RE),
        .HALF_MI (HALF_MI)
    ) u_tone_gen (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_active (key_active_r),
        .tone_out   (tone_out)
    );

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Playback counterpart of the piano key recorder.
- Accepts recorded note events (key_address, start_time, duration; 0.01 s units) into a small event buffer.
- On `play`, replays the events against its own 0.01 s timeline, driving the active key code and a square-wave tone.
- Monophonic; sits between the recorder's event outputs and the audio/LED output logic.

Parameters:
- TICK_DIV, 500000: CLOCK_50 cycles per 0.01 s tick. Use 4 in simulation.
- DEPTH, 16: number of event entries (power of 2).
- HALF_DO, 95420: tone half-period in cycles for key 2'b01 (262 Hz).
- HALF_RE, 85034: tone half-period for key 2'b10 (294 Hz).
- HALF_MI, 75758: tone half-period for key 2'b11 (330 Hz).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write one event; accepted only in IDLE when not full.
- wr_key  in  2  event key: 00 rest, 01 do, 10 re, 11 mi.
- wr_start  in  13  event start time, ticks.
- wr_dur  in  13  event duration, ticks.
- clear  in  1  empty the buffer; accepted only in IDLE.
- play  in  1  start playback; single-cycle pulse.
- stop  in  1  abort playback.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  number of stored events.
- busy  out  1  high in any state other than IDLE.
- key_active  out  2  currently sounding key; 00 when silent.
- tone_out  out  1  square wave for key_active; 0 when silent.
- play_time  out  13  playback timeline, ticks.
- done  out  1  one-cycle pulse at the end of playback.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; count = 0.
  - key_active, tone_out, play_time, done, busy, rd_idx all 0.
  - Tick prescaler = TICK_DIV-1.
- Buffer:
  - Events are stored in write order at index `count`; count increments.
  - Entries are not consumed by playback, so a stored sequence can be replayed.
  - wr_en while full or not IDLE: ignored, no state change.
  - clear and wr_en in the same cycle: clear wins, count = 0.
- Timeline:
  - The prescaler runs only while busy and emits a tick when it reaches 0, then reloads TICK_DIV-1.
  - play_time increments on each tick and saturates at 8191.
- play in IDLE:
  - count == 0: done pulses the next cycle; state stays IDLE.
  - count > 0: next cycle state = FETCH, rd_idx = 0, play_time = 0, prescaler = TICK_DIV-1.
- play while busy: ignored.
- FSM:
  - IDLE: as above.
  - FETCH (1 cycle): buffer read is registered; latch key/start/dur of entry rd_idx; go to WAIT.
  - WAIT:
    - If play_time >= start: dur == 0 goes to NEXT; otherwise go to SOUND with remain = dur and key_active = key.
    - Evaluated every cycle, so a late event starts immediately.
    - Overlapping events are therefore delayed, never truncated.
  - SOUND: each tick decrements remain; when remain reaches 0, key_active = 00 and go to NEXT.
    - Sound length = dur ticks ± 1 tick of prescaler phase.
  - NEXT (1 cycle): if rd_idx == count-1, go to DONE; otherwise rd_idx += 1 and go to FETCH.
  - DONE (1 cycle): done = 1; next state IDLE; play_time holds its last value.
- Rest events (key 00) occupy time with key_active = 00 and tone_out = 0.
- stop, any busy state: next cycle state = IDLE, key_active = 00, tone_out = 0, no done pulse; buffer kept.
- stop has priority over play in the same cycle.
- Tone:
  - The half-period counter reloads whenever key_active changes.
  - tone_out toggles each time the counter expires.
  - tone_out is forced to 0 when key_active == 00.
  - The first toggle to 1 occurs HALF_x cycles after the key becomes active.

Decomposition:
- Shared package piano_pkg holds:
  - key codes KEY_NONE/KEY_DO/KEY_RE/KEY_MI;
  - TIME_W = 13;
  - TICK_DIV default;
  - HALF_* constants;
  - the FSM state enum.
- The recorder and this player both use piano_pkg.
- One natural sub-module: tone_gen (inputs: key_active; output: tone_out; contains the half-period counter and the per-key divisor select).

Test Plan:
- Write 3 events {01,2,3}, {10,6,2}, {11,8,1}, then play → key_active = 01 for ticks 2..4, 10 for ticks 6..7, 11 for tick 8; done pulses once; count stays 3.
- Write {01,0,5}, {10,1,2} (overlap) → key 10 starts as soon as key 01 ends at tick 5, lasts 2 ticks; done after tick 7.
- Fill to 16 entries, then issue a 17th wr_en → full = 1, count = 16, entry 15 unchanged; then clear → count = 0, full = 0.
- Play with count = 0 → done high exactly one cycle later, busy never rises.
- Assert stop during SOUND of key 11 → next cycle key_active = 00, tone_out = 0, busy = 0, no done; play again → sequence restarts from entry 0 and play_time = 0.
- Assert reset mid-SOUND (async, between clock edges) → all outputs 0 immediately; count = 0; play with empty buffer → done pulse only.
- With HALF_DO = 3 and key 01 active → tone_out has a 6-cycle period; on key change to 00 → tone_out = 0 the same cycle key_active changes.
